// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared FSM encodings, status bit indices and reset divisor for the UART transmitter
package uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Bit positions of the transmitter flags inside uart_status.
    localparam int STAT_TX_BUSY = 0;
    localparam int STAT_TX_FULL = 1;

    // Reset value of uart_cfg; the register file uses the same constant.
    localparam logic [7:0] UART_DIV_RST = 8'd17;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - loadable bit-period down-counter with a per-bit tick
//
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset
//   load_i  capture div_i as the frame divisor and restart the count
//   div_i   clocks per bit minus 1
//   en_i    count enable (frame in progress)
//   tick_o  high in the last clock of each bit period
module uart_baud_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             en_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;

    // The tick must not depend on load_i: the FSM decides to load from the tick.
    assign tick_o = en_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        if (load_i) begin
            div_d = div_i;
            cnt_d = div_i;
        end else if (en_i) begin
            // Reload from the divisor latched for this frame, not from div_i.
            cnt_d = (cnt_q == '0) ? div_q : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            div_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART serialiser with a one-entry holding buffer
//
// Ports:
//   clk_i         system clock
//   rst_i         synchronous active-high reset
//   send_valid_i  byte offered
//   send_data_i   byte to transmit
//   send_ready_o  holding buffer free
//   baud_div_i    clocks per bit minus 1, sampled at frame start
//   tx_o          serial output, idle high, driven from a flop
//   tx_busy_o     frame in progress
//   tx_full_o     holding buffer occupied
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             send_valid_i,
    input  logic [7:0]       send_data_i,
    output logic             send_ready_o,
    input  logic [DIV_W-1:0] baud_div_i,
    output logic             tx_o,
    output logic             tx_busy_o,
    output logic             tx_full_o
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] buf_q, buf_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic                 full_q, full_d;
    logic                 tx_q, tx_d;
    logic                 drain;
    logic                 load;
    logic                 tick;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (load),
        .div_i  (baud_div_i),
        .en_i   (tx_busy_o),
        .tick_o (tick)
    );

    assign send_ready_o = ~full_q;
    assign tx_full_o    = full_q;
    assign tx_busy_o    = (state_q != ST_IDLE);
    assign tx_o         = tx_q;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        full_d  = full_q;
        tx_d    = tx_q;
        drain   = 1'b0;
        load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (full_q) begin
                    drain = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                        stop_d  = 1'b0;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop_q == LAST_STOP) begin
                        if (full_q) begin
                            drain = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Move the held byte into the shifter and open a new frame; from STOP
        // this chains straight into START with no idle bit in between.
        if (drain) begin
            state_d = ST_START;
            tx_d    = 1'b0;
            shift_d = buf_q;
            full_d  = 1'b0;
            bit_d   = '0;
            stop_d  = 1'b0;
            load    = 1'b1;
        end

        // Accept only into an empty buffer, so this never overlaps a drain.
        if (send_valid_i && !full_q) begin
            buf_d  = send_data_i[DATA_BITS-1:0];
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            full_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            full_q  <= full_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send_valid = 1'b0;
    logic [7:0] send_data = 8'h00;
    logic       send_ready;
    logic [7:0] baud_div = 8'd17;
    logic       tx;
    logic       tx_busy;
    logic       tx_full;

    int n_assert = 0;
    int n_fail   = 0;

    logic rec_tx[$];
    logic rec_busy[$];
    logic exp_tx[$];
    logic exp_busy[$];

    uart_tx dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .send_valid_i (send_valid),
        .send_data_i  (send_data),
        .send_ready_o (send_ready),
        .baud_div_i   (baud_div),
        .tx_o         (tx),
        .tx_busy_o    (tx_busy),
        .tx_full_o    (tx_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        rec_tx.push_back(tx);
        rec_busy.push_back(tx_busy);
    endtask

    task automatic offer(input logic [7:0] d);
        send_data  = d;
        send_valid = 1'b1;
        tick();
        send_valid = 1'b0;
    endtask

    task automatic clear_all();
        rec_tx.delete();
        rec_busy.delete();
        exp_tx.delete();
        exp_busy.delete();
    endtask

    // Reference: an 8N1 frame is start(0), data LSB first, stop(1),
    // each level held for div+1 clocks.
    task automatic add_frame(input logic [7:0] d, input int div);
        for (int b = 0; b < 10; b++) begin
            logic v;
            if (b == 0)      v = 1'b0;
            else if (b == 9) v = 1'b1;
            else             v = d[b-1];
            for (int k = 0; k <= div; k++) begin
                exp_tx.push_back(v);
                exp_busy.push_back(1'b1);
            end
        end
    endtask

    // The accept edge itself is the first sample: still idle.
    task automatic add_idle(input int n);
        for (int k = 0; k < n; k++) begin
            exp_tx.push_back(1'b1);
            exp_busy.push_back(1'b0);
        end
    endtask

    task automatic compare(input string tag, input int busy_clks);
        int mism  = 0;
        int busyn = 0;
        for (int i = 0; i < rec_tx.size(); i++) begin
            logic et, eb;
            et = (i < exp_tx.size()) ? exp_tx[i] : 1'b1;
            eb = (i < exp_busy.size()) ? exp_busy[i] : 1'b0;
            if (rec_tx[i] !== et || rec_busy[i] !== eb) mism++;
            if (rec_busy[i] === 1'b1) busyn++;
        end
        chk({tag, "_wave_mismatch"}, mism, 0);
        chk({tag, "_busy_clks"}, busyn, busy_clks);
        chk({tag, "_recorded_enough"}, int'(rec_tx.size() > exp_tx.size()), 1);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_full", tx_full, 0);
        chk("rst_ready", send_ready, 1);

        // Single byte at the default divisor
        clear_all();
        baud_div = 8'd17;
        offer(8'hA5);
        chk("single_full_after_accept", tx_full, 1);
        chk("single_ready_after_accept", send_ready, 0);
        repeat (200) tick();
        add_idle(1);
        add_frame(8'hA5, 17);
        compare("single_a5", 180);

        // Back-to-back plus an overflow offer that must be dropped
        clear_all();
        offer(8'h55);
        repeat (5) tick();
        chk("b2b_ready_while_busy", send_ready, 1);
        offer(8'h0F);
        chk("b2b_full_second", tx_full, 1);
        chk("b2b_ready_second", send_ready, 0);
        offer(8'hAA);
        chk("overflow_full_kept", tx_full, 1);
        repeat (400) tick();
        add_idle(1);
        add_frame(8'h55, 17);
        add_frame(8'h0F, 17);
        compare("b2b_overflow", 360);

        // Divisor change mid-frame takes effect on the next frame only
        clear_all();
        baud_div = 8'd17;
        offer(8'h3C);
        repeat (3) tick();
        offer(8'hC3);
        repeat (30) tick();
        baud_div = 8'd3;
        repeat (260) tick();
        add_idle(1);
        add_frame(8'h3C, 17);
        add_frame(8'hC3, 3);
        compare("div_change", 220);

        // Divisor 0: one clock per bit
        clear_all();
        baud_div = 8'd0;
        offer(8'hFF);
        repeat (20) tick();
        add_idle(1);
        add_frame(8'hFF, 0);
        compare("div0_ff", 10);

        // Reset mid-frame aborts immediately with no residual bits
        clear_all();
        baud_div = 8'd17;
        offer(8'h00);
        offer(8'h00);
        repeat (50) tick();
        rst = 1'b1;
        tick();
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", tx_busy, 0);
        chk("midrst_full", tx_full, 0);
        chk("midrst_ready", send_ready, 1);
        repeat (2) tick();
        rst = 1'b0;
        clear_all();
        repeat (60) tick();
        add_idle(1);
        compare("post_rst_quiet", 0);

        // Random bytes, divisors and optional back-to-back second byte
        for (int it = 0; it < 8; it++) begin
            int         div;
            logic [7:0] d1, d2;
            int         two;
            int         gap;
            clear_all();
            div = $urandom_range(0, 5);
            d1  = 8'($urandom);
            d2  = 8'($urandom);
            two = $urandom_range(0, 1);
            gap = $urandom_range(1, 5 * (div + 1));
            baud_div = 8'(div);
            offer(d1);
            add_idle(1);
            add_frame(d1, div);
            if (two == 1) begin
                repeat (gap - 1) tick();
                offer(d2);
                add_frame(d2, div);
            end
            repeat (25 * (div + 1) + 10) tick();
            compare($sformatf("rand%0d", it), (two + 1) * 10 * (div + 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
